// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and state definitions for the logic unit arbiter
// Contents:
//   OPW                          opcode width
//   OP_AND/OP_OR/OP_XOR/OP_NOR   opcode encodings
//   state_t                      response slot state (EMPTY/FULL)
package alu_pkg;

    localparam int OPW = 2;

    localparam logic [OPW-1:0] OP_AND = 2'b00;
    localparam logic [OPW-1:0] OP_OR  = 2'b01;
    localparam logic [OPW-1:0] OP_XOR = 2'b10;
    localparam logic [OPW-1:0] OP_NOR = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - bitwise logic unit (AND/OR/XOR/NOR), no carry, no flags
// Ports:
//   op   in   opcode from alu_pkg
//   a,b  in   operands
//   y    out  result
module logic_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [alu_pkg::OPW-1:0] op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic [WIDTH-1:0]        y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant, purely combinational
// Ports:
//   valid0, valid1  in   requests
//   last_grant      in   id of the most recently accepted requester
//   slot_free       in   downstream slot can take a result this cycle
//   grant0, grant1  out  one-hot (or zero) grant, already qualified by slot_free
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic slot_free,
    output logic grant0,
    output logic grant1
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant0 = slot_free & valid0 & (~valid1 | last_grant);
        grant1 = slot_free & valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - shares one bitwise logic slice between two valid/ready requesters
// Ports:
//   clock, reset                   clock, async active-high reset
//   req0_valid/ready/op/a/b        requester 0 channel
//   req1_valid/ready/op/a/b        requester 1 channel
//   rsp_valid/ready/data/id        registered response channel, tagged with requester id
module logic_unit_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    // A held result that is being drained this cycle frees the slot, so a
    // new operation can be accepted on the same edge (1 op/cycle).
    assign slot_free = (state == EMPTY) | rsp_ready;

    rr_arbiter_2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .slot_free  (slot_free),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0 & ~reset;
    assign req1_ready = grant1 & ~reset;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Operand mux: only the granted requester drives the slice.
    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant1) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    logic_slice #(.WIDTH(WIDTH)) u_slice (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (result)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    // Output logic
    always_comb begin
        rsp_valid = (state == FULL);
    end

    // Response register and priority pointer; both move only on an accept,
    // so a drain leaves the stale data/id in place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_data   <= result;
            rsp_id     <= grant1;
            last_grant <= grant1;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    logic_unit_arbiter #(.WIDTH(32), .OPW(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Behavioural model: one output slot holding (valid, data, id), plus
    // the id of the last accepted requester.
    logic        m_valid, m_id, m_last;
    logic [31:0] m_data;
    logic        n_valid, n_id, n_last, have_nxt;
    logic [31:0] n_data;

    always @(negedge clock) begin
        if (!reset) begin
            bit free, w0, w1;
            free = !m_valid || rsp_ready;
            w0 = free && req0_valid && (!req1_valid || m_last == 1'b1);
            w1 = free && req1_valid && (!req0_valid || m_last == 1'b0);
            check("ready0", {31'd0, req0_ready}, {31'd0, w0});
            check("ready1", {31'd0, req1_ready}, {31'd0, w1});
            check("no_double_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
            n_valid = m_valid && !rsp_ready;
            n_data  = m_data;
            n_id    = m_id;
            n_last  = m_last;
            if (w0) begin
                n_valid = 1'b1; n_data = f(req0_op, req0_a, req0_b); n_id = 1'b0; n_last = 1'b0;
            end else if (w1) begin
                n_valid = 1'b1; n_data = f(req1_op, req1_a, req1_b); n_id = 1'b1; n_last = 1'b1;
            end
            have_nxt = 1'b1;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0; m_data = 32'd0; m_id = 1'b0; m_last = 1'b1; have_nxt = 1'b0;
        end else if (have_nxt) begin
            m_valid = n_valid; m_data = n_data; m_id = n_id; m_last = n_last; have_nxt = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    logic [31:0] op_exp [4];

    initial begin
        op_exp[0] = 32'hAAAA_0000;
        op_exp[1] = 32'hFFFF_AAAA;
        op_exp[2] = 32'h5555_AAAA;
        op_exp[3] = 32'h0000_5555;

        reset = 1'b1;
        rsp_ready = 1'b1;
        drive0(1'b1, 2'd0, 32'd0, 32'd0);
        drive1(1'b1, 2'd0, 32'd0, 32'd0);
        #2;
        check("reset_ready0", {31'd0, req0_ready}, 32'd0);
        check("reset_ready1", {31'd0, req1_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        drive0(1'b0, 2'd0, 32'd0, 32'd0);
        drive1(1'b0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        step();

        // 1: single OR on req0
        drive0(1'b1, 2'b01, 32'h0000_00F0, 32'h0000_000F);
        #1 check("t1_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        drive0(1'b0, 2'd0, 32'd0, 32'd0);
        check("t1_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_data", rsp_data, 32'h0000_00FF);
        check("t1_id", {31'd0, rsp_id}, 32'd0);

        // req1 alone so that the tie sequence below starts with req0
        drive1(1'b1, 2'b10, 32'h1234_5678, 32'h0F0F_0F0F);
        step();
        check("pre2_id", {31'd0, rsp_id}, 32'd1);
        check("pre2_data", rsp_data, 32'h1D3B_5977);

        // 2: both valid, alternating grants
        drive0(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
            check("t2_id", {31'd0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("t2_valid", {31'd0, rsp_valid}, 32'd1);
        end

        // 3: stall with both requesting; last result came from req1
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_ready0", {31'd0, req0_ready}, 32'd0);
            check("t3_ready1", {31'd0, req1_ready}, 32'd0);
            step();
            check("t3_id", {31'd0, rsp_id}, 32'd1);
            check("t3_data", rsp_data, 32'h1D3B_5977);
            check("t3_valid", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        #1 check("t3_release_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        check("t3_release_id", {31'd0, rsp_id}, 32'd0);
        check("t3_release_data", rsp_data, 32'h0000_FFFF);
        check("t3_release_valid", {31'd0, rsp_valid}, 32'd1);
        drive1(1'b0, 2'd0, 32'd0, 32'd0);

        // 4: every opcode on req0
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 2'(i), 32'hAAAA_AAAA, 32'hFFFF_0000);
            step();
            check("t4_op_data", rsp_data, op_exp[i]);
        end
        drive0(1'b0, 2'd0, 32'd0, 32'd0);
        step();
        check("t4_drained", {31'd0, rsp_valid}, 32'd0);
        check("t4_data_kept", rsp_data, 32'h0000_5555);

        // 5: reset while a result is stalled
        drive1(1'b1, 2'b01, 32'h0000_0001, 32'h0000_0002);
        step();
        drive1(1'b0, 2'd0, 32'd0, 32'd0);
        rsp_ready = 1'b0;
        step();
        check("t5_held", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_async_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_async_data", rsp_data, 32'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        rsp_ready = 1'b1;
        drive0(1'b1, 2'b10, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        drive1(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h1111_1111);
        #1;
        check("t5_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("t5_tie_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        check("t5_tie_data", rsp_data, 32'h0F0F_0F0F);
        drive0(1'b0, 2'd0, 32'd0, 32'd0);
        step();
        check("t5_second_id", {31'd0, rsp_id}, 32'd1);

        // 6: req1 alone for four ops, then a tie
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, 2'b11, 32'(i), 32'h0000_0100);
            step();
            check("t6_solo_id", {31'd0, rsp_id}, 32'd1);
            check("t6_solo_data", rsp_data, ~(32'(i) | 32'h0000_0100));
        end
        drive0(1'b1, 2'b01, 32'h8000_0000, 32'h0000_0001);
        #1;
        check("t6_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("t6_tie_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        check("t6_tie_id", {31'd0, rsp_id}, 32'd0);
        check("t6_tie_data", rsp_data, 32'h8000_0001);
        repeat (4) step();
        drive0(1'b0, 2'd0, 32'd0, 32'd0);
        drive1(1'b0, 2'd0, 32'd0, 32'd0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
